// File: rtl/spw_buffer_reader.sv
// Drain side of the SPW buffer: owns the per-entry valid bits, pops entries strictly in
// ring order over a valid/ready port, tracks occupancy and flags writes to live entries.
module spw_buffer_reader #(
  parameter int PTR_WIDTH = 3,
  localparam int DEPTH = 1 << PTR_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [PTR_WIDTH-1:0] write_ptr_i,
  input  logic                 flush_i,
  input  logic                 rd_ready_i,
  output logic                 rd_valid_o,
  output logic [PTR_WIDTH-1:0] rd_ptr_o,
  output logic [DEPTH-1:0]     valid_array_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 err_wr_valid_o
);

  logic [DEPTH-1:0]     valid_reg, valid_next;
  logic [PTR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_WIDTH:0]   count_reg, count_next;
  logic                 err_reg, err_next;

  logic head_valid;
  logic pop;
  logic wr_hit;
  logic legal_wr;
  logic illegal_wr;

  assign head_valid = valid_reg[rd_ptr_reg];
  assign pop        = head_valid & rd_ready_i;
  // Hit is judged on the pre-update bit, so a write landing on the entry being popped
  // in the same cycle is still an error.
  assign wr_hit     = valid_reg[write_ptr_i];
  assign legal_wr   = wr_en_i & ~wr_hit;
  assign illegal_wr = wr_en_i & wr_hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic clr;
      logic set;
      assign clr = pop && (rd_ptr_reg == PTR_WIDTH'(gi));
      assign set = wr_en_i && (write_ptr_i == PTR_WIDTH'(gi));
      // Clear before set: a same-entry pop+write leaves the entry valid.
      assign valid_next[gi] = ~flush_i & ((valid_reg[gi] & ~clr) | set);
    end
  endgenerate

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    err_next    = err_reg;
    if (flush_i) begin
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_WIDTH'(1);
      end
      count_next = count_reg + {{PTR_WIDTH{1'b0}}, legal_wr} - {{PTR_WIDTH{1'b0}}, pop};
      if (illegal_wr) begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg  <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      valid_reg  <= valid_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      err_reg    <= err_next;
    end
  end

  assign rd_valid_o     = head_valid;
  assign rd_ptr_o       = rd_ptr_reg;
  assign valid_array_o  = valid_reg;
  assign count_o        = count_reg;
  assign empty_o        = (count_reg == '0);
  assign full_o         = (count_reg == (PTR_WIDTH + 1)'(DEPTH));
  assign err_wr_valid_o = err_reg;

endmodule

// File: tb/tb_spw_buffer_reader.sv
// Self-checking bench for spw_buffer_reader: table of {inputs, expected state} vectors
// fed through a scoreboard queue, followed by hand-written full-buffer corner sequences.
module tb_spw_buffer_reader;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [2:0] write_ptr_i = '0;
  logic       flush_i = 1'b0;
  logic       rd_ready_i = 1'b0;
  logic       rd_valid_o;
  logic [2:0] rd_ptr_o;
  logic [7:0] valid_array_o;
  logic [3:0] count_o;
  logic       empty_o;
  logic       full_o;
  logic       err_wr_valid_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  spw_buffer_reader #(.PTR_WIDTH(3)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wr_en_i        (wr_en_i),
    .write_ptr_i    (write_ptr_i),
    .flush_i        (flush_i),
    .rd_ready_i     (rd_ready_i),
    .rd_valid_o     (rd_valid_o),
    .rd_ptr_o       (rd_ptr_o),
    .valid_array_o  (valid_array_o),
    .count_o        (count_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .err_wr_valid_o (err_wr_valid_o)
  );

  typedef struct packed {
    logic       rst;
    logic       we;
    logic [2:0] wp;
    logic       fl;
    logic       rr;
    logic [7:0] v;
    logic [2:0] rp;
    logic [3:0] cnt;
    logic       err;
    logic       rv;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   vec_idx = 0;

  function automatic vec_t mk(logic rst, logic we, int wp, logic fl, logic rr,
                              int v, int rp, int cnt, logic err, logic rv);
    vec_t t;
    t.rst = rst; t.we = we; t.wp = 3'(wp); t.fl = fl; t.rr = rr;
    t.v = 8'(v); t.rp = 3'(rp); t.cnt = 4'(cnt); t.err = err; t.rv = rv;
    return t;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, vec_idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    vec_t e;
    rst_i       = t.rst;
    wr_en_i     = t.we;
    write_ptr_i = t.wp;
    flush_i     = t.fl;
    rd_ready_i  = t.rr;
    sb.push_back(t);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    chk("valid_array", valid_array_o, e.v);
    chk("rd_ptr", {5'b0, rd_ptr_o}, {5'b0, e.rp});
    chk("count", {4'b0, count_o}, {4'b0, e.cnt});
    chk("rd_valid", {7'b0, rd_valid_o}, {7'b0, e.rv});
    chk("err", {7'b0, err_wr_valid_o}, {7'b0, e.err});
    chk("empty", {7'b0, empty_o}, {7'b0, (e.cnt == 4'd0)});
    chk("full", {7'b0, full_o}, {7'b0, (e.cnt == 4'd8)});
    $display("vec %0d rst=%0b we=%0b wp=%0d fl=%0b rr=%0b -> v=%02h rp=%0d cnt=%0d rv=%0b err=%0b",
             vec_idx, t.rst, t.we, t.wp, t.fl, t.rr,
             valid_array_o, rd_ptr_o, count_o, rd_valid_o, err_wr_valid_o);
    vec_idx++;
  endtask

  initial begin
    //             rst we wp fl rr   v     rp cnt err rv
    // In-order fill and drain; ready with nothing valid is a no-op.
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h01, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h03, 0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 2, 0, 0, 8'h07, 0, 3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h06, 1, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h04, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 3, 0, 0, 0));
    // Head-of-line blocking, then flush with a write to a live entry (err stays 0).
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 8'h02, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h03, 0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 8'h00, 0, 0, 0, 0));
    // Fill all entries, then drain with wrap 7 -> 0.
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, i, 0, 0, (1 << (i + 1)) - 1, 0, i + 1, 0, 1));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 255 & ~((1 << (k + 1)) - 1), (k + 1) % 8, 7 - k, 0, k < 7));
    // Double write to entry 3: sticky error, count not incremented.
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 8'h08, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 8'h08, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h08, 0, 1, 1, 0));
    // Entries 0..4, head moved to 2, error raised, then flush with write and pop.
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, i, 0, 0, (1 << (i + 1)) - 1, 0, i + 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h1E, 1, 4, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h1C, 2, 3, 0, 1));
    tbl.push_back(mk(0, 1, 4, 0, 0, 8'h1C, 2, 3, 1, 1));
    tbl.push_back(mk(0, 1, 5, 1, 1, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0));
    // Head at 5: pop + write 6 keeps count; then same-entry pop + write on 6.
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 1, i, 0, 0, (1 << (i + 1)) - 1, 0, i + 1, 0, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 8'h3F & ~((1 << (k + 1)) - 1), k + 1, 5 - k, 0, 1));
    tbl.push_back(mk(0, 1, 6, 0, 1, 8'h40, 6, 1, 0, 1));
    tbl.push_back(mk(0, 1, 6, 0, 1, 8'h40, 7, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h40, 7, 0, 1, 0));
    // Reset overrides flush and drops in-flight write/pop.
    tbl.push_back(mk(1, 1, 7, 1, 1, 8'h00, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Writes while full are always illegal; a same-entry pop+write while full
    // leaves the entry valid and drops the count by one.
    apply(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    for (int i = 7; i >= 0; i--)
      apply(mk(0, 1, i, 0, 0, 8'hFF & ~((1 << i) - 1), 0, 8 - i, 0, i == 0));
    apply(mk(0, 1, 5, 0, 0, 8'hFF, 0, 8, 1, 1));
    apply(mk(0, 1, 0, 0, 1, 8'hFF, 1, 7, 1, 1));
    apply(mk(0, 0, 0, 0, 1, 8'hFD, 2, 6, 1, 1));
    apply(mk(0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0));

    rst_i = 1'b0; wr_en_i = 1'b0; flush_i = 1'b0; rd_ready_i = 1'b0;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    checks++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
